// File: rtl/result_serializer.sv
// Parallel-to-serial converter for result words: LSB- or MSB-first framing with
// an optional trailing even-parity bit and a valid/ready handshake on both sides.
module result_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             tx_valid,
  output logic             tx_bit,
  output logic             tx_last,
  input  logic             tx_ready,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] DATA_END = CW'(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = PARITY_EN ? CW'(WIDTH) : CW'(WIDTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_count;
  logic             r_parity;
  logic             r_done;

  logic             w_busy;
  logic             w_accept;
  logic             w_hs;
  logic             w_at_last;
  logic             w_in_parity;
  logic             w_data_bit;
  logic [WIDTH-1:0] w_shift_next;

  function automatic logic f_parity_step(input logic acc, input logic data_bit);
    return acc ^ data_bit;
  endfunction

  // Handshake qualifiers and next-shift value derived from the current state.
  always_comb begin
    w_busy       = (r_state == SHIFT);
    w_accept     = !w_busy && in_valid;
    w_hs         = w_busy && tx_ready;
    w_at_last    = (r_count == LAST_IDX);
    w_in_parity  = PARITY_EN && (r_count == DATA_END);
    w_data_bit   = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
    w_shift_next = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};
  end

  // Output decodes: only state and shift-register contents reach the tx side.
  always_comb begin
    in_ready = !w_busy;
    tx_valid = w_busy;
    tx_last  = w_busy && w_at_last;
    done     = r_done;
    if (!w_busy) begin
      tx_bit = 1'b0;
    end else if (w_in_parity) begin
      tx_bit = r_parity;
    end else begin
      tx_bit = w_data_bit;
    end
  end

  // Frame state machine: capture a word in IDLE, shift one bit per handshake.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_shift  <= {WIDTH{1'b0}};
      r_count  <= {CW{1'b0}};
      r_parity <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_hs && w_at_last;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift  <= in_data;
            r_count  <= {CW{1'b0}};
            r_parity <= 1'b0;
            r_state  <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          if (w_hs) begin
            r_shift <= w_shift_next;
            r_count <= r_count + CW'(1);
            // The parity bit itself is not folded back into the accumulator.
            if (!w_in_parity) begin
              r_parity <= f_parity_step(r_parity, w_data_bit);
            end else begin
              r_parity <= r_parity;
            end
            if (w_at_last) begin
              r_state <= IDLE;
            end else begin
              r_state <= SHIFT;
            end
          end else begin
            r_state <= SHIFT;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: lane 0 is LSB-first without parity, lane 1 is
// MSB-first with even parity; a negedge monitor scores bits against a queue.
module tb_result_serializer;

  logic       CLK;
  logic       RST;
  logic [1:0] iv;
  logic [1:0] rdy;
  logic [7:0] dat0;
  logic [7:0] dat1;
  logic [1:0] ir;
  logic [1:0] tv;
  logic [1:0] tbit;
  logic [1:0] tl;
  logic [1:0] dn;

  int total = 0;
  int bad   = 0;

  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic [1:0] pend;
  logic [1:0] hold;
  logic [1:0] pbit;
  logic [1:0] plast;
  logic [1:0] done_seen;
  int         hs_cnt[2];

  typedef struct {
    int         lane;
    logic [7:0] data;
    logic [8:0] frame;
    int         len;
  } vec_t;

  vec_t vecs[9];

  result_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) dut_a (
    .CLK(CLK), .RST(RST), .in_valid(iv[0]), .in_data(dat0), .in_ready(ir[0]),
    .tx_valid(tv[0]), .tx_bit(tbit[0]), .tx_last(tl[0]), .tx_ready(rdy[0]), .done(dn[0])
  );

  result_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut_b (
    .CLK(CLK), .RST(RST), .in_valid(iv[1]), .in_data(dat1), .in_ready(ir[1]),
    .tx_valid(tv[1]), .tx_bit(tbit[1]), .tx_last(tl[1]), .tx_ready(rdy[1]), .done(dn[1])
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int l, input logic [1:0] e);
    if (l == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Per-lane scoreboard step, run once per falling edge.
  task automatic mon_lane(input int l);
    logic [1:0] e;
    int         qs;
    chk("done", {31'd0, dn[l]}, {31'd0, pend[l]});
    if (pend[l]) begin
      chk("done_in_ready", {31'd0, ir[l]}, 32'd1);
      done_seen[l] = 1'b1;
    end
    pend[l] = 1'b0;
    if (tv[l]) begin
      chk("busy_in_ready", {31'd0, ir[l]}, 32'd0);
      if (hold[l]) begin
        chk("hold_bit", {31'd0, tbit[l]}, {31'd0, pbit[l]});
        chk("hold_last", {31'd0, tl[l]}, {31'd0, plast[l]});
      end
      if (rdy[l]) begin
        qs = (l == 0) ? q0.size() : q1.size();
        total++;
        if (qs == 0) begin
          bad++;
          $display("FAIL extra_bit: lane=%0d got an unexpected handshake want none", l);
        end else begin
          if (l == 0) e = q0.pop_front();
          else e = q1.pop_front();
          chk("tx_bit", {31'd0, tbit[l]}, {31'd0, e[1]});
          chk("tx_last", {31'd0, tl[l]}, {31'd0, e[0]});
          if (e[0]) pend[l] = 1'b1;
          hs_cnt[l]++;
        end
      end
      hold[l]  = !rdy[l];
      pbit[l]  = tbit[l];
      plast[l] = tl[l];
    end else begin
      hold[l] = 1'b0;
      chk("idle_outputs", {29'd0, tbit[l], tl[l], ir[l]}, 32'd1);
    end
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      pend = 2'b00;
      hold = 2'b00;
    end else begin
      for (int l = 0; l < 2; l++) mon_lane(l);
    end
  end

  task automatic drive(input int l, input logic [7:0] d, input logic [8:0] fr, input int len);
    chk("drive_in_ready", {31'd0, ir[l]}, 32'd1);
    if (l == 0) dat0 = d;
    else dat1 = d;
    iv[l] = 1'b1;
    done_seen[l] = 1'b0;
    for (int i = 0; i < len; i++) push_exp(l, {fr[i], (i == len - 1)});
  endtask

  task automatic accept(input int l);
    @(posedge CLK);
    #1;
    iv[l] = 1'b0;
    chk("first_bit_latency", {31'd0, tv[l]}, 32'd1);
  endtask

  task automatic wait_done(input int l, input int mode);
    int k;
    for (k = 0; k < 200; k++) begin
      rdy[l] = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      @(posedge CLK);
      #1;
      if (done_seen[l]) break;
    end
    rdy[l] = 1'b1;
    chk("done_timeout", {31'd0, done_seen[l]}, 32'd1);
    chk("frame_len", (l == 0) ? q0.size() : q1.size(), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    for (int l = 0; l < 2; l++) begin
      chk(nm, {27'd0, tv[l], tbit[l], tl[l], dn[l], ir[l]}, 32'd1);
    end
  endtask

  initial begin
    int s;
    vecs[0] = '{0, 8'hA5, 9'h0A5, 8};
    vecs[1] = '{0, 8'h3C, 9'h03C, 8};
    vecs[2] = '{0, 8'hFF, 9'h0FF, 8};
    vecs[3] = '{0, 8'h00, 9'h000, 8};
    vecs[4] = '{0, 8'h80, 9'h080, 8};
    vecs[5] = '{1, 8'h07, 9'h1E0, 9};
    vecs[6] = '{1, 8'hA5, 9'h0A5, 9};
    vecs[7] = '{1, 8'h01, 9'h180, 9};
    vecs[8] = '{1, 8'hC0, 9'h003, 9};

    RST = 1'b1; iv = 2'b00; rdy = 2'b11; dat0 = 8'h00; dat1 = 8'h00;
    pend = 2'b00; hold = 2'b00; pbit = 2'b00; plast = 2'b00; done_seen = 2'b00;
    hs_cnt[0] = 0; hs_cnt[1] = 0;
    #1;
    chk_reset_outputs("reset_state");
    repeat (3) @(posedge CLK);
    #1;

    // Word offered while reset releases is taken on the very next edge.
    drive(0, 8'hC3, 9'h0C3, 8);
    RST = 1'b0;
    accept(0);
    wait_done(0, 0);

    for (int v = 0; v < 9; v++) begin
      drive(vecs[v].lane, vecs[v].data, vecs[v].frame, vecs[v].len);
      accept(vecs[v].lane);
      wait_done(vecs[v].lane, 0);
    end

    // tx_ready stalls with a 1,0,0 pattern.
    drive(0, 8'h3C, 9'h03C, 8);
    accept(0);
    s = hs_cnt[0];
    wait_done(0, 1);
    chk("stall_handshakes", hs_cnt[0] - s, 32'd8);

    // New data and in_valid pulses during SHIFT must be ignored.
    drive(0, 8'h5A, 9'h05A, 8);
    accept(0);
    @(posedge CLK); #1;
    dat0 = 8'hFF; iv[0] = 1'b1;
    chk("shift_in_ready", {31'd0, ir[0]}, 32'd0);
    @(posedge CLK); #1;
    chk("shift_in_ready", {31'd0, ir[0]}, 32'd0);
    iv[0] = 1'b0;
    @(posedge CLK); #1;
    dat0 = 8'h00;
    wait_done(0, 0);

    // Back-to-back words with in_valid held high.
    drive(0, 8'h01, 9'h001, 8);
    @(posedge CLK); #1;
    dat0 = 8'h80;
    for (int i = 0; i < 8; i++) push_exp(0, {(i == 7), (i == 7)});
    chk("b2b_first_valid", {31'd0, tv[0]}, 32'd1);
    for (int k = 1; k < 8; k++) begin
      @(posedge CLK); #1;
      chk("b2b_busy", {31'd0, ir[0]}, 32'd0);
    end
    @(posedge CLK); #1;
    chk("b2b_done_cycle", {30'd0, ir[0], dn[0]}, 32'd3);
    @(posedge CLK); #1;
    chk("b2b_second_start", {29'd0, tv[0], tbit[0], ir[0]}, 32'd4);
    iv[0] = 1'b0;
    done_seen[0] = 1'b0;
    wait_done(0, 0);

    // Asynchronous reset mid-frame after the third bit.
    drive(0, 8'hA5, 9'h0A5, 8);
    accept(0);
    s = hs_cnt[0];
    for (int k = 0; k < 50; k++) begin
      if (hs_cnt[0] - s >= 3) break;
      @(posedge CLK);
    end
    chk("abort_reach_bit3", hs_cnt[0] - s, 32'd3);
    #3;
    RST = 1'b1;
    q0.delete();
    #1;
    chk_reset_outputs("async_reset");
    @(posedge CLK); #1;
    chk_reset_outputs("reset_hold");
    drive(0, 8'hFF, 9'h0FF, 8);
    RST = 1'b0;
    accept(0);
    wait_done(0, 0);

    repeat (3) @(posedge CLK);
    #1;
    chk("final_q0", q0.size(), 32'd0);
    chk("final_q1", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
